// File: rtl/uart_port_if.sv
// uart_port_if: CPU-side strobe interface of the j1 uart0 I/O slot.
//   uart0_wr    : one-cycle write strobe, pushes uart_w into the TX FIFO
//   uart_w      : TX byte, sampled with uart0_wr
//   uart0_rd    : one-cycle read strobe, consumes the held RX byte
//   uart0_valid : RX holding register full
//   uart0_data  : held RX byte
//   tx_full     : TX FIFO full
//   rx_err      : sticky framing/overrun flag
// master = CPU side, slave = UART side.
interface uart_port_if;
   logic       uart0_wr;
   logic [7:0] uart_w;
   logic       uart0_rd;
   logic       uart0_valid;
   logic [7:0] uart0_data;
   logic       tx_full;
   logic       rx_err;

   modport master (
      output uart0_wr, uart_w, uart0_rd,
      input  uart0_valid, uart0_data, tx_full, rx_err
   );

   modport slave (
      input  uart0_wr, uart_w, uart0_rd,
      output uart0_valid, uart0_data, tx_full, rx_err
   );
endinterface

// File: rtl/uart_port.sv
// uart_port: 8N1 byte UART for the j1 I/O space.
// CPU writes are queued in a TX FIFO and serialised on uart_tx; frames on
// uart_rx are deserialised into a one-byte holding register.
// Ports:
//   clk     : single clock, rising edge
//   resetq  : asynchronous active-low reset
//   bus     : uart_port_if.slave (strobes, RX byte, status flags)
//   uart_tx : serial out, idle high, registered
//   uart_rx : serial in, asynchronous to clk
module uart_port #(
   parameter int CLKFREQ = 74250000,
   parameter int BAUD    = 115200,
   parameter int TXDEPTH = 16
) (
   input  logic       clk,
   input  logic       resetq,
   uart_port_if.slave bus,
   output logic       uart_tx,
   input  logic       uart_rx
);
   localparam int DIV = (CLKFREQ + BAUD / 2) / BAUD;
   localparam int CW  = $clog2(DIV + 1);
   localparam int AW  = $clog2(TXDEPTH);
   localparam logic [CW-1:0] DIV_C  = CW'(DIV);
   localparam logic [CW-1:0] HALF_C = CW'(DIV / 2);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

   // Full when the wrap bits differ and the index bits match.
   function automatic logic full_f(input logic [AW:0] w, input logic [AW:0] r);
      return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
   endfunction

   // ---------------- TX FIFO ----------------
   logic [7:0]  mem_r [TXDEPTH];
   logic [AW:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
   logic        push_s, pop_s, empty_s, tx_full_r;

   // Full is judged on pre-edge pointers, so a same-cycle pop never makes room.
   assign push_s   = bus.uart0_wr & ~full_f(wr_ptr_r, rd_ptr_r);
   assign empty_s  = (wr_ptr_r == rd_ptr_r);
   assign wr_ptr_s = wr_ptr_r + {{AW{1'b0}}, push_s};
   assign rd_ptr_s = rd_ptr_r + {{AW{1'b0}}, pop_s};

   // FIFO storage write port (data only, needs no reset)
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= bus.uart_w;
   end

   // FIFO pointers and registered full flag
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         tx_full_r <= 1'b0;
      end else begin
         wr_ptr_r  <= wr_ptr_s;
         rd_ptr_r  <= rd_ptr_s;
         tx_full_r <= full_f(wr_ptr_s, rd_ptr_s);
      end
   end

   // ---------------- TX FSM ----------------
   state_t        tx_state_r, tx_state_s;
   logic [CW-1:0] tx_cnt_r, tx_cnt_s;
   logic [2:0]    tx_bit_r, tx_bit_s;
   logic [7:0]    tx_sh_r, tx_sh_s;
   logic          tx_exp_s, tx_s, tx_r;

   assign tx_exp_s = (tx_cnt_r == ONE_C);

   // TX next state, shifter, bit counter, baud counter and FIFO pop
   always_comb begin
      tx_state_s = tx_state_r;
      tx_cnt_s   = tx_cnt_r - ONE_C;
      tx_bit_s   = tx_bit_r;
      tx_sh_s    = tx_sh_r;
      pop_s      = 1'b0;
      case (tx_state_r)
         S_IDLE: begin
            tx_cnt_s = DIV_C;
            if (!empty_s) begin
               pop_s      = 1'b1;
               tx_sh_s    = mem_r[rd_ptr_r[AW-1:0]];
               tx_state_s = S_START;
            end else begin
               tx_state_s = S_IDLE;
            end
         end
         S_START: begin
            if (tx_exp_s) begin
               tx_cnt_s   = DIV_C;
               tx_bit_s   = 3'd0;
               tx_state_s = S_DATA;
            end else begin
               tx_state_s = S_START;
            end
         end
         S_DATA: begin
            if (tx_exp_s) begin
               tx_cnt_s   = DIV_C;
               tx_sh_s    = {1'b0, tx_sh_r[7:1]};
               tx_bit_s   = tx_bit_r + 3'd1;
               tx_state_s = (tx_bit_r == 3'd7) ? S_STOP : S_DATA;
            end else begin
               tx_state_s = S_DATA;
            end
         end
         S_STOP: begin
            if (tx_exp_s) begin
               tx_cnt_s = DIV_C;
               // Pending byte goes straight to START so frames abut.
               if (!empty_s) begin
                  pop_s      = 1'b1;
                  tx_sh_s    = mem_r[rd_ptr_r[AW-1:0]];
                  tx_state_s = S_START;
               end else begin
                  tx_state_s = S_IDLE;
               end
            end else begin
               tx_state_s = S_STOP;
            end
         end
         default: tx_state_s = S_IDLE;
      endcase
   end

   // Line level for the current TX state; registered one edge later.
   assign tx_s = (tx_state_r == S_START) ? 1'b0 :
                 (tx_state_r == S_DATA)  ? tx_sh_r[0] : 1'b1;

   // TX state and output registers
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         tx_state_r <= S_IDLE;
         tx_cnt_r   <= DIV_C;
         tx_bit_r   <= 3'd0;
         tx_sh_r    <= 8'd0;
         tx_r       <= 1'b1;
      end else begin
         tx_state_r <= tx_state_s;
         tx_cnt_r   <= tx_cnt_s;
         tx_bit_r   <= tx_bit_s;
         tx_sh_r    <= tx_sh_s;
         tx_r       <= tx_s;
      end
   end

   // ---------------- RX ----------------
   logic          rx_sync_r, rxs_r;
   state_t        rx_state_r, rx_state_s;
   logic [CW-1:0] rx_cnt_r, rx_cnt_s;
   logic [2:0]    rx_bit_r, rx_bit_s;
   logic [7:0]    rx_sh_r, rx_sh_s, data_r;
   logic          rx_exp_s, stop_s, load_s, ovr_s, ferr_s, clr_s, valid_r, err_r;

   assign rx_exp_s = (rx_cnt_r == ONE_C);

   // RX next state; the START check at half a bit rejects short glitches
   always_comb begin
      rx_state_s = rx_state_r;
      rx_cnt_s   = rx_cnt_r - ONE_C;
      rx_bit_s   = rx_bit_r;
      rx_sh_s    = rx_sh_r;
      stop_s     = 1'b0;
      case (rx_state_r)
         S_IDLE: begin
            rx_cnt_s   = HALF_C;
            rx_state_s = rxs_r ? S_IDLE : S_START;
         end
         S_START: begin
            if (rx_exp_s) begin
               rx_cnt_s   = DIV_C;
               rx_bit_s   = 3'd0;
               rx_state_s = rxs_r ? S_IDLE : S_DATA;
            end else begin
               rx_state_s = S_START;
            end
         end
         S_DATA: begin
            if (rx_exp_s) begin
               rx_cnt_s   = DIV_C;
               rx_sh_s    = {rxs_r, rx_sh_r[7:1]};
               rx_bit_s   = rx_bit_r + 3'd1;
               rx_state_s = (rx_bit_r == 3'd7) ? S_STOP : S_DATA;
            end else begin
               rx_state_s = S_DATA;
            end
         end
         S_STOP: begin
            // Back to IDLE at mid-stop so the next start bit is caught early.
            if (rx_exp_s) begin
               stop_s     = 1'b1;
               rx_state_s = S_IDLE;
            end else begin
               rx_state_s = S_STOP;
            end
         end
         default: rx_state_s = S_IDLE;
      endcase
   end

   // Frame completion: a read in the same cycle frees the holding register.
   assign ferr_s = stop_s & ~rxs_r;
   assign load_s = stop_s & rxs_r & (~valid_r | bus.uart0_rd);
   assign ovr_s  = stop_s & rxs_r & valid_r & ~bus.uart0_rd;
   assign clr_s  = bus.uart0_rd & valid_r;

   // RX synchroniser, FSM and holding register
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_sync_r  <= 1'b1;
         rxs_r      <= 1'b1;
         rx_state_r <= S_IDLE;
         rx_cnt_r   <= HALF_C;
         rx_bit_r   <= 3'd0;
         rx_sh_r    <= 8'd0;
         data_r     <= 8'd0;
         valid_r    <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         rx_sync_r  <= uart_rx;
         rxs_r      <= rx_sync_r;
         rx_state_r <= rx_state_s;
         rx_cnt_r   <= rx_cnt_s;
         rx_bit_r   <= rx_bit_s;
         rx_sh_r    <= rx_sh_s;
         data_r     <= load_s ? rx_sh_r : data_r;
         valid_r    <= load_s | (valid_r & ~clr_s);
         err_r      <= ferr_s | ovr_s | (err_r & ~clr_s);
      end
   end

   assign uart_tx         = tx_r;
   assign bus.uart0_valid = valid_r;
   assign bus.uart0_data  = data_r;
   assign bus.tx_full     = tx_full_r;
   assign bus.rx_err      = err_r;
endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: directed self-checking bench for uart_port at DIV = 16.
module tb_uart_port;
   logic clk = 1'b0;
   logic resetq;
   logic uart_rx;
   logic uart_tx;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   uart_port_if bus();

   uart_port #(.CLKFREQ(1600), .BAUD(100), .TXDEPTH(16)) dut (
      .clk(clk), .resetq(resetq), .bus(bus), .uart_tx(uart_tx), .uart_rx(uart_rx)
   );

   always #5 clk = ~clk;

   // Edge counter: at a falling edge, cyc is the index of the last rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_edge(input int e);
      @(negedge clk);
      while (cyc < e) @(negedge clk);
   endtask

   // Sample the ten bits of a TX frame whose start bit begins after edge s.
   task automatic capture_tx(input int s, output logic [9:0] bits);
      for (int b = 0; b < 10; b++) begin
         wait_edge(s + 16 * b + 8);
         bits[b] = uart_tx;
      end
   endtask

   // Drive one RX frame, 16 clocks per bit; uart0_rd pulses at offset rd_at.
   task automatic send_rx(input logic [7:0] b, input logic stop, input int rd_at);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int n = 0; n < 160; n++) begin
         @(negedge clk);
         uart_rx = f[n / 16];
         bus.uart0_rd = (n == rd_at);
      end
      uart_rx = 1'b1;
      bus.uart0_rd = 1'b0;
   endtask

   task automatic rd_pulse();
      @(negedge clk);
      bus.uart0_rd = 1'b1;
      @(negedge clk);
      bus.uart0_rd = 1'b0;
   endtask

   task automatic test_reset();
      resetq = 1'b0;
      bus.uart0_wr = 1'b0;
      bus.uart_w = 8'h00;
      bus.uart0_rd = 1'b0;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
      checks++; if (bus.uart0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.uart0_valid); end
      checks++; if (bus.uart0_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.uart0_data); end
      checks++; if (bus.tx_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.tx_full); end
      checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.rx_err); end
      resetq = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_tx_single();
      int e;
      int lows;
      logic [9:0] bits;
      @(negedge clk);
      bus.uart0_wr = 1'b1;
      bus.uart_w = 8'h55;
      @(negedge clk);
      e = cyc;
      bus.uart0_wr = 1'b0;
      wait_edge(e + 1);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_lat_n1: got %b expected 1", uart_tx); end
      wait_edge(e + 2);
      checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL tx_lat_n2: got %b expected 0", uart_tx); end
      capture_tx(e + 2, bits);
      checks++; if (bits !== 10'b1_0101_0101_0) begin errors++; $display("FAIL tx_frame55: got %b expected 1010101010", bits); end
      lows = 0;
      for (int i = 155; i < 300; i++) begin
         wait_edge(e + i);
         if (uart_tx !== 1'b1) lows++;
      end
      checks++; if (lows !== 0) begin errors++; $display("FAIL tx_stop_idle: got %0d low clocks expected 0", lows); end
   endtask

   task automatic test_back_to_back();
      int e0;
      int lows;
      @(negedge clk);
      e0 = cyc + 1;
      fork
         begin
            for (int i = 0; i < 18; i++) begin
               if (i > 0) @(negedge clk);
               if (i == 16) begin
                  checks++; if (bus.tx_full !== 1'b0) begin errors++; $display("FAIL full_16th: got %b expected 0", bus.tx_full); end
               end
               if (i == 17) begin
                  checks++; if (bus.tx_full !== 1'b1) begin errors++; $display("FAIL full_17th: got %b expected 1", bus.tx_full); end
               end
               bus.uart0_wr = 1'b1;
               bus.uart_w = 8'(i);
            end
            @(negedge clk);
            bus.uart0_wr = 1'b0;
            wait_edge(e0 + 160);
            checks++; if (bus.tx_full !== 1'b1) begin errors++; $display("FAIL full_before_pop2: got %b expected 1", bus.tx_full); end
            wait_edge(e0 + 161);
            checks++; if (bus.tx_full !== 1'b0) begin errors++; $display("FAIL full_after_pop2: got %b expected 0", bus.tx_full); end
         end
         begin
            logic [9:0] bits;
            logic [9:0] exp;
            for (int f = 0; f < 17; f++) begin
               capture_tx(e0 + 2 + 160 * f, bits);
               exp = {1'b1, 8'(f), 1'b0};
               checks++; if (bits !== exp) begin errors++; $display("FAIL b2b_frame%0d: got %b expected %b", f, bits, exp); end
            end
         end
      join
      lows = 0;
      for (int i = 2722; i < 2900; i++) begin
         wait_edge(e0 + i);
         if (uart_tx !== 1'b1) lows++;
      end
      checks++; if (lows !== 0) begin errors++; $display("FAIL b2b_drop_0x11: got %0d low clocks expected 0", lows); end
   endtask

   task automatic test_rx_basic();
      send_rx(8'hA3, 1'b1, -1);
      checks++; if (bus.uart0_valid !== 1'b1) begin errors++; $display("FAIL rx_valid: got %b expected 1", bus.uart0_valid); end
      checks++; if (bus.uart0_data !== 8'hA3) begin errors++; $display("FAIL rx_data: got %h expected a3", bus.uart0_data); end
      checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL rx_err: got %b expected 0", bus.rx_err); end
      rd_pulse();
      checks++; if (bus.uart0_valid !== 1'b0) begin errors++; $display("FAIL rx_read_clr: got %b expected 0", bus.uart0_valid); end
      checks++; if (bus.uart0_data !== 8'hA3) begin errors++; $display("FAIL rx_data_kept: got %h expected a3", bus.uart0_data); end
   endtask

   task automatic test_overrun();
      send_rx(8'h12, 1'b1, -1);
      send_rx(8'h34, 1'b1, -1);
      checks++; if (bus.uart0_data !== 8'h12) begin errors++; $display("FAIL ovr_data: got %h expected 12", bus.uart0_data); end
      checks++; if (bus.rx_err !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b expected 1", bus.rx_err); end
      rd_pulse();
      checks++; if (bus.uart0_valid !== 1'b0) begin errors++; $display("FAIL ovr_rd_valid: got %b expected 0", bus.uart0_valid); end
      checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL ovr_rd_err: got %b expected 0", bus.rx_err); end
      send_rx(8'h9C, 1'b1, -1);
      send_rx(8'h3C, 1'b1, -1);
      // Stop sample happens on offset 154 of the frame.
      send_rx(8'h56, 1'b1, 154);
      checks++; if (bus.uart0_valid !== 1'b1) begin errors++; $display("FAIL coinc_valid: got %b expected 1", bus.uart0_valid); end
      checks++; if (bus.uart0_data !== 8'h56) begin errors++; $display("FAIL coinc_data: got %h expected 56", bus.uart0_data); end
      checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL coinc_err: got %b expected 0", bus.rx_err); end
      rd_pulse();
   endtask

   task automatic test_line_errors();
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (bus.uart0_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", bus.uart0_valid); end
      checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL glitch_err: got %b expected 0", bus.rx_err); end
      send_rx(8'h77, 1'b0, -1);
      repeat (20) @(negedge clk);
      checks++; if (bus.uart0_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", bus.uart0_valid); end
      checks++; if (bus.rx_err !== 1'b1) begin errors++; $display("FAIL ferr_err: got %b expected 1", bus.rx_err); end
      send_rx(8'h01, 1'b1, -1);
      checks++; if (bus.uart0_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b expected 1", bus.uart0_valid); end
      checks++; if (bus.uart0_data !== 8'h01) begin errors++; $display("FAIL good_data: got %h expected 01", bus.uart0_data); end
      checks++; if (bus.rx_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus.rx_err); end
      rd_pulse();
      checks++; if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL err_rd_clr: got %b expected 0", bus.rx_err); end
   endtask

   task automatic test_reset_mid_frame();
      int e;
      int lows;
      @(negedge clk);
      e = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         bus.uart0_wr = 1'b1;
         bus.uart_w = 8'h00;
      end
      @(negedge clk);
      bus.uart0_wr = 1'b0;
      wait_edge(e + 40);
      checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_data_low: got %b expected 0", uart_tx); end
      resetq = 1'b0;
      #1;
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b expected 1", uart_tx); end
      repeat (3) @(negedge clk);
      resetq = 1'b1;
      lows = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      checks++; if (lows !== 0) begin errors++; $display("FAIL mid_no_resume: got %0d low clocks expected 0", lows); end
      checks++; if (bus.tx_full !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", bus.tx_full); end
   endtask

   initial begin
      test_reset();
      test_tx_single();
      test_back_to_back();
      test_rx_basic();
      test_overrun();
      test_line_errors();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
